// File: rtl/kiwi_mon_pkg.sv
// Shared types and helpers for the Kiwi run monitor.
// Holds the FSM state enum, syndrome marker constants and is_finished().
package kiwi_mon_pkg;

   // Widest syndrome the helper below can classify.
   localparam int SYN_W_MAX = 32;

   typedef logic [SYN_W_MAX-1:0] syn_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUN,
      ST_SETTLE,
      ST_DONE,
      ST_TOUT
   } state_e;

   // 0 = still running, all-ones = healthy idle.
   localparam syn_t SYN_OK   = '0;
   localparam syn_t SYN_IDLE = '1;

   // syn is zero-extended to SYN_W_MAX; w is the real channel width.
   function automatic logic is_finished(input syn_t syn,
                                        input int unsigned w);
      syn_t idle_v;
      idle_v = SYN_IDLE >> (SYN_W_MAX - w);
      return (syn != SYN_OK) && (syn != idle_v);
   endfunction

endpackage

// File: rtl/kiwi_mon_prio_sel.sv
// Lowest-index-set selector over an N-bit request mask.
// Ports: req_i (mask) -> valid_o (any bit set), idx_o (lowest set bit).
module kiwi_mon_prio_sel #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req_i,
   output logic             valid_o,
   output logic [IDX_W-1:0] idx_o
);

   always_comb begin
      valid_o = |req_i;
      idx_o   = '0;
      // Scan downward so the lowest set bit is written last.
      for (int i = N - 1; i >= 0; i--) begin
         if (req_i[i]) idx_o = IDX_W'(i);
      end
   end

endmodule

// File: rtl/kiwi_run_monitor.sv
// Multi-channel run monitor: tick counter, debounced finish, watchdog.
// Ports: clk, reset (async, active-low), start/clear pulses,
//   hpr_abend_syndrome (N_CH packed syndromes) in; busy, done,
//   timed_out, code, code_ch, fin_mask, clock_ticks out (all registered).
// Optional: define KIWI_RUN_MONITOR_STAMP_EN to add fin_stamp, holding
//   per-channel clock_ticks at the cycle that channel first finished.
// SYN_W must not exceed kiwi_mon_pkg::SYN_W_MAX.
module kiwi_run_monitor
   import kiwi_mon_pkg::*;
#(
   parameter int N_CH     = 4,
   parameter int SYN_W    = 8,
   parameter int SETTLE   = 8,
   parameter int CNT_W    = 32,
   parameter int TIMEOUT  = 1000000,
   parameter int ALL_MODE = 0,
   localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  clear,
   input  logic [N_CH*SYN_W-1:0] hpr_abend_syndrome,
   output logic                  busy,
   output logic                  done,
   output logic                  timed_out,
   output logic [SYN_W-1:0]      code,
   output logic [CH_W-1:0]       code_ch,
   output logic [N_CH-1:0]       fin_mask,
   output logic [CNT_W-1:0]      clock_ticks
`ifdef KIWI_RUN_MONITOR_STAMP_EN
   ,
   output logic [N_CH*CNT_W-1:0] fin_stamp
`endif
);

   localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT - 1);
   localparam logic [7:0]       SET_LIM = 8'(SETTLE - 1);

   state_e             state_q;
   logic               busy_q;
   logic               done_q;
   logic               tout_q;
   logic [SYN_W-1:0]   code_q;
   logic [CH_W-1:0]    code_ch_q;
   logic [N_CH-1:0]    fin_mask_q;
   logic [N_CH-1:0]    fin_mask_d;
   logic [CNT_W-1:0]   ticks_q;
   logic [CNT_W-1:0]   ticks_d;
   logic [7:0]         settle_q;

   logic [N_CH-1:0]    fin_now;
   logic [N_CH-1:0]    sel_req;
   logic               sel_vld;
   logic [CH_W-1:0]    sel_idx;
   logic [SYN_W-1:0]   sel_syn;
   logic               armed;
   logic               trig;
   logic               settle_exp;
   logic               to_hit;

   always_comb begin
      fin_now = '0;
      for (int i = 0; i < N_CH; i++) begin
         fin_now[i] = is_finished(
            syn_t'(hpr_abend_syndrome[i*SYN_W +: SYN_W]), SYN_W);
      end
   end

   assign armed      = (state_q == ST_RUN) || (state_q == ST_SETTLE);
   assign fin_mask_d = fin_mask_q | fin_now;
   assign ticks_d    = (&ticks_q) ? ticks_q : ticks_q + 1'b1;
   assign trig       = (ALL_MODE != 0) ? (&fin_mask_d) : (|fin_mask_d);
   assign settle_exp = (state_q == ST_SETTLE) && (settle_q == SET_LIM);
   assign to_hit     = (TIMEOUT != 0) && (ticks_q == TO_LIM);

   // Prefer channels finished right now; fall back to the sticky mask
   // when every finished channel has since dropped back.
   assign sel_req = (|fin_now) ? fin_now : fin_mask_q;

   kiwi_mon_prio_sel #(
      .N     (N_CH),
      .IDX_W (CH_W)
   ) u_sel (
      .req_i   (sel_req),
      .valid_o (sel_vld),
      .idx_o   (sel_idx)
   );

   always_comb begin
      sel_syn = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (sel_vld && (CH_W'(i) == sel_idx))
            sel_syn = hpr_abend_syndrome[i*SYN_W +: SYN_W];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         tout_q     <= 1'b0;
         code_q     <= '0;
         code_ch_q  <= '0;
         fin_mask_q <= '0;
         ticks_q    <= '0;
         settle_q   <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q    <= ST_RUN;
                  busy_q     <= 1'b1;
                  ticks_q    <= '0;
                  fin_mask_q <= '0;
                  code_q     <= '0;
                  code_ch_q  <= '0;
               end
            end
            ST_RUN, ST_SETTLE: begin
               fin_mask_q <= fin_mask_d;
               // Settle expiry outranks the watchdog on the same edge.
               if (settle_exp) begin
                  state_q   <= ST_DONE;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  code_q    <= sel_syn;
                  code_ch_q <= sel_idx;
                  ticks_q   <= ticks_d;
               end else if (to_hit) begin
                  // Tick count freezes at TIMEOUT-1.
                  state_q   <= ST_TOUT;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  tout_q    <= 1'b1;
                  code_q    <= '1;
                  code_ch_q <= '0;
               end else begin
                  ticks_q <= ticks_d;
                  if (state_q == ST_SETTLE) begin
                     settle_q <= settle_q + 8'd1;
                  end else if (trig) begin
                     state_q  <= ST_SETTLE;
                     settle_q <= '0;
                  end
               end
            end
            ST_DONE, ST_TOUT: begin
               if (clear) begin
                  state_q <= ST_IDLE;
                  done_q  <= 1'b0;
                  tout_q  <= 1'b0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign timed_out   = tout_q;
   assign code        = code_q;
   assign code_ch     = code_ch_q;
   assign fin_mask    = fin_mask_q;
   assign clock_ticks = ticks_q;

`ifdef KIWI_RUN_MONITOR_STAMP_EN
   logic [N_CH*CNT_W-1:0] stamp_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stamp_q <= '0;
      end else if (state_q == ST_IDLE) begin
         if (start) stamp_q <= '0;
      end else if (armed) begin
         for (int i = 0; i < N_CH; i++) begin
            if (fin_now[i] && !fin_mask_q[i])
               stamp_q[i*CNT_W +: CNT_W] <= ticks_q;
         end
      end
   end

   assign fin_stamp = stamp_q;
`endif

endmodule

// File: tb/tb_kiwi_run_monitor.sv
// Self-checking bench for kiwi_run_monitor: directed scenarios plus
// randomized syndrome traces checked against a trace-level model.
module tb_kiwi_run_monitor;

   localparam int TL  = 300;
   localparam int SET = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_a, clear_a, start_b, clear_b;
   logic [31:0] syn_a, syn_b;
   logic        busy_a, done_a, to_a, busy_b, done_b, to_b;
   logic [7:0]  code_a, code_b;
   logic [1:0]  ch_a, ch_b;
   logic [3:0]  mask_a, mask_b;
   logic [31:0] ticks_a, ticks_b;
`ifdef KIWI_RUN_MONITOR_STAMP_EN
   logic [127:0] stamp_a, stamp_b;
`endif

   logic [7:0]  tr [TL][4];
   int          n_tests = 0;
   int          n_fail = 0;
   int          obs_done;
   int          m_end;
   int          m_first [4];
   bit          m_to;
   logic [7:0]  m_code;
   logic [1:0]  m_ch;
   logic [3:0]  m_mask;
   logic [31:0] m_ticks;

   always #5 clk = ~clk;

   kiwi_run_monitor #(
      .N_CH(4), .SYN_W(8), .SETTLE(SET), .CNT_W(32),
      .TIMEOUT(TL), .ALL_MODE(0)
   ) u_any (
      .clk(clk), .reset(rst_n), .start(start_a), .clear(clear_a),
      .hpr_abend_syndrome(syn_a), .busy(busy_a), .done(done_a),
      .timed_out(to_a), .code(code_a), .code_ch(ch_a),
      .fin_mask(mask_a), .clock_ticks(ticks_a)
`ifdef KIWI_RUN_MONITOR_STAMP_EN
      , .fin_stamp(stamp_a)
`endif
   );

   kiwi_run_monitor #(
      .N_CH(4), .SYN_W(8), .SETTLE(SET), .CNT_W(32),
      .TIMEOUT(TL), .ALL_MODE(1)
   ) u_all (
      .clk(clk), .reset(rst_n), .start(start_b), .clear(clear_b),
      .hpr_abend_syndrome(syn_b), .busy(busy_b), .done(done_b),
      .timed_out(to_b), .code(code_b), .code_ch(ch_b),
      .fin_mask(mask_b), .clock_ticks(ticks_b)
`ifdef KIWI_RUN_MONITOR_STAMP_EN
      , .fin_stamp(stamp_b)
`endif
   );

   function automatic bit is_fin(input logic [7:0] s);
      return (s != 8'h00) && (s != 8'hFF);
   endfunction

   function automatic logic [31:0] cyc_syn(input int k);
      if (k >= TL) return $urandom;
      return {tr[k][3], tr[k][2], tr[k][1], tr[k][0]};
   endfunction

   task automatic fill(input logic [7:0] v);
      for (int t = 0; t < TL; t++)
         for (int c = 0; c < 4; c++) tr[t][c] = v;
   endtask

   task automatic put(input int c, input int from, input int upto,
                      input logic [7:0] v);
      for (int t = from; t <= upto; t++) tr[t][c] = v;
   endtask

   // Outcome of one armed run from the trace, by the monitor's rules:
   // find the trigger tick, decide DONE vs watchdog, pick the code.
   task automatic model(input bit all_mode);
      int trig, cnt, pick;
      trig = -1;
      for (int c = 0; c < 4; c++) begin
         m_first[c] = -1;
         for (int t = 0; t < TL; t++)
            if (m_first[c] < 0 && is_fin(tr[t][c])) m_first[c] = t;
      end
      for (int t = 0; t < TL && trig < 0; t++) begin
         cnt = 0;
         for (int c = 0; c < 4; c++)
            if (m_first[c] >= 0 && m_first[c] <= t) cnt++;
         if (all_mode ? (cnt == 4) : (cnt > 0)) trig = t;
      end
      if (trig >= 0 && trig + SET <= TL - 1) begin
         m_to = 0;
         m_end = trig + SET;
         m_ticks = 32'(m_end + 1);
         pick = -1;
         for (int c = 3; c >= 0; c--)
            if (is_fin(tr[m_end][c])) pick = c;
         if (pick < 0)
            for (int c = 3; c >= 0; c--)
               if (m_first[c] >= 0 && m_first[c] <= m_end) pick = c;
         m_ch = 2'(pick);
         m_code = tr[m_end][pick];
      end else begin
         m_to = 1;
         m_end = TL - 1;
         m_ticks = 32'(TL - 1);
         m_code = 8'hFF;
         m_ch = 2'd0;
      end
      for (int c = 0; c < 4; c++)
         m_mask[c] = (m_first[c] >= 0) && (m_first[c] <= m_end);
   endtask

   // Arm one instance and play the trace; obs_done = edges after the
   // start edge until done is first seen (-1 if never within ncyc+1).
   task automatic play(input bit inst, input int ncyc);
      obs_done = -1;
      @(negedge clk);
      if (inst) start_b = 1'b1;
      else start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      start_b = 1'b0;
      for (int k = 0; k <= ncyc; k++) begin
         if (inst) syn_b = cyc_syn(k);
         else syn_a = cyc_syn(k);
         @(posedge clk); #1;
         if (obs_done < 0 && (inst ? done_b : done_a)) obs_done = k + 1;
      end
   endtask

   task automatic do_clear(input bit inst);
      @(negedge clk);
      if (inst) clear_b = 1'b1;
      else clear_a = 1'b1;
      @(posedge clk); #1;
      clear_a = 1'b0;
      clear_b = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", busy_a); end
      n_tests++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b want 0", done_a); end
      n_tests++; if (to_a !== 1'b0) begin n_fail++; $display("FAIL reset timed_out: got %b want 0", to_a); end
      n_tests++; if (code_a !== 8'h00) begin n_fail++; $display("FAIL reset code: got %h want 00", code_a); end
      n_tests++; if (ch_a !== 2'd0) begin n_fail++; $display("FAIL reset code_ch: got %0d want 0", ch_a); end
      n_tests++; if (mask_a !== 4'h0) begin n_fail++; $display("FAIL reset fin_mask: got %b want 0000", mask_a); end
      n_tests++; if (ticks_a !== 32'd0) begin n_fail++; $display("FAIL reset ticks: got %0d want 0", ticks_a); end
      n_tests++; if (done_b !== 1'b0) begin n_fail++; $display("FAIL reset done_all: got %b want 0", done_b); end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic_finish();
      fill(8'h00);
      put(2, 20, TL - 1, 8'h01);
      play(0, 32);
      n_tests++; if (obs_done !== 29) begin n_fail++; $display("FAIL basic done edge: got %0d want 29", obs_done); end
      n_tests++; if (code_a !== 8'h01) begin n_fail++; $display("FAIL basic code: got %h want 01", code_a); end
      n_tests++; if (ch_a !== 2'd2) begin n_fail++; $display("FAIL basic code_ch: got %0d want 2", ch_a); end
      n_tests++; if (mask_a !== 4'b0100) begin n_fail++; $display("FAIL basic fin_mask: got %b want 0100", mask_a); end
      n_tests++; if (to_a !== 1'b0) begin n_fail++; $display("FAIL basic timed_out: got %b want 0", to_a); end
      n_tests++; if (ticks_a !== 32'd29) begin n_fail++; $display("FAIL basic ticks: got %0d want 29", ticks_a); end
      n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL basic busy: got %b want 0", busy_a); end
`ifdef KIWI_RUN_MONITOR_STAMP_EN
      n_tests++; if (stamp_a[64 +: 32] !== 32'd20) begin n_fail++; $display("FAIL basic stamp ch2: got %0d want 20", stamp_a[64 +: 32]); end
`endif
      do_clear(0);
   endtask

   task automatic test_glitch();
      fill(8'h00);
      put(3, 10, 13, 8'h05);
      put(1, 12, TL - 1, 8'h07);
      play(0, 24);
      n_tests++; if (obs_done !== 19) begin n_fail++; $display("FAIL glitch done edge: got %0d want 19", obs_done); end
      n_tests++; if (code_a !== 8'h07) begin n_fail++; $display("FAIL glitch code: got %h want 07", code_a); end
      n_tests++; if (ch_a !== 2'd1) begin n_fail++; $display("FAIL glitch code_ch: got %0d want 1", ch_a); end
      n_tests++; if (mask_a !== 4'b1010) begin n_fail++; $display("FAIL glitch fin_mask: got %b want 1010", mask_a); end
      do_clear(0);
   endtask

   task automatic test_all_mode();
      fill(8'h00);
      put(0, 5, TL - 1, 8'h11);
      put(1, 9, TL - 1, 8'h22);
      put(2, 40, TL - 1, 8'h33);
      put(3, 41, TL - 1, 8'h44);
      play(1, 55);
      n_tests++; if (obs_done !== 50) begin n_fail++; $display("FAIL all done edge: got %0d want 50", obs_done); end
      n_tests++; if (code_b !== 8'h11) begin n_fail++; $display("FAIL all code: got %h want 11", code_b); end
      n_tests++; if (ch_b !== 2'd0) begin n_fail++; $display("FAIL all code_ch: got %0d want 0", ch_b); end
      n_tests++; if (mask_b !== 4'b1111) begin n_fail++; $display("FAIL all fin_mask: got %b want 1111", mask_b); end
      n_tests++; if (ticks_b !== 32'd50) begin n_fail++; $display("FAIL all ticks: got %0d want 50", ticks_b); end
      do_clear(1);
   endtask

   task automatic test_control();
      fill(8'h00);
      put(1, 10, TL - 1, 8'h3C);
      obs_done = -1;
      @(negedge clk);
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      for (int k = 0; k <= 22; k++) begin
         syn_a = cyc_syn(k);
         start_a = (k == 5);
         clear_a = (k == 5);
         @(posedge clk); #1;
         if (obs_done < 0 && done_a) obs_done = k + 1;
         if (k == 5) begin
            n_tests++; if (ticks_a !== 32'd6) begin n_fail++; $display("FAIL ctl start ignored ticks: got %0d want 6", ticks_a); end
            n_tests++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL ctl clear ignored busy: got %b want 1", busy_a); end
         end
      end
      start_a = 1'b0;
      clear_a = 1'b0;
      n_tests++; if (obs_done !== 19) begin n_fail++; $display("FAIL ctl done edge: got %0d want 19", obs_done); end
      do_clear(0);
      n_tests++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL clear done: got %b want 0", done_a); end
      n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL clear busy: got %b want 0", busy_a); end
      n_tests++; if (code_a !== 8'h3C) begin n_fail++; $display("FAIL clear code kept: got %h want 3c", code_a); end
      n_tests++; if (mask_a !== 4'b0010) begin n_fail++; $display("FAIL clear mask kept: got %b want 0010", mask_a); end
      n_tests++; if (ticks_a !== 32'd19) begin n_fail++; $display("FAIL clear ticks kept: got %0d want 19", ticks_a); end
   endtask

   task automatic test_idle_marker();
      syn_a = 32'hFFFF_FFFF;
      obs_done = -1;
      @(negedge clk);
      start_a = 1'b1;
      clear_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      clear_a = 1'b0;
      n_tests++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL start+clear busy: got %b want 1", busy_a); end
      n_tests++; if (ticks_a !== 32'd0) begin n_fail++; $display("FAIL start+clear ticks: got %0d want 0", ticks_a); end
      for (int k = 0; k < 499; k++) begin
         @(posedge clk); #1;
         if (obs_done < 0 && done_a) obs_done = k + 1;
      end
      n_tests++; if (obs_done !== TL) begin n_fail++; $display("FAIL tout done edge: got %0d want %0d", obs_done, TL); end
      n_tests++; if (to_a !== 1'b1) begin n_fail++; $display("FAIL tout timed_out: got %b want 1", to_a); end
      n_tests++; if (code_a !== 8'hFF) begin n_fail++; $display("FAIL tout code: got %h want ff", code_a); end
      n_tests++; if (ch_a !== 2'd0) begin n_fail++; $display("FAIL tout code_ch: got %0d want 0", ch_a); end
      n_tests++; if (ticks_a !== 32'd299) begin n_fail++; $display("FAIL tout ticks: got %0d want 299", ticks_a); end
      n_tests++; if (mask_a !== 4'b0000) begin n_fail++; $display("FAIL tout fin_mask: got %b want 0000", mask_a); end
      do_clear(0);
   endtask

   task automatic test_reset_mid_settle();
      fill(8'h00);
      put(0, 20, TL - 1, 8'h09);
      @(negedge clk);
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      for (int k = 0; k < 25; k++) begin
         syn_a = cyc_syn(k);
         @(posedge clk); #1;
      end
      syn_a = cyc_syn(25);
      n_tests++; if (ticks_a !== 32'd25) begin n_fail++; $display("FAIL rst pre ticks: got %0d want 25", ticks_a); end
      #2 rst_n = 1'b0;
      #1;
      n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL async rst busy: got %b want 0", busy_a); end
      n_tests++; if (mask_a !== 4'h0) begin n_fail++; $display("FAIL async rst mask: got %b want 0000", mask_a); end
      n_tests++; if (ticks_a !== 32'd0) begin n_fail++; $display("FAIL async rst ticks: got %0d want 0", ticks_a); end
      n_tests++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL async rst done: got %b want 0", done_a); end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      syn_a = 32'h0000_0900;
      @(negedge clk);
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      n_tests++; if (ticks_a !== 32'd0) begin n_fail++; $display("FAIL rearm ticks: got %0d want 0", ticks_a); end
      repeat (8) @(posedge clk);
      #1;
      n_tests++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL rearm early done: got %b want 0", done_a); end
      @(posedge clk); #1;
      n_tests++; if (done_a !== 1'b1) begin n_fail++; $display("FAIL rearm done: got %b want 1", done_a); end
      n_tests++; if (code_a !== 8'h09 || ch_a !== 2'd1) begin n_fail++; $display("FAIL rearm code: got %h/%0d want 09/1", code_a, ch_a); end
      n_tests++; if (ticks_a !== 32'd9) begin n_fail++; $display("FAIL rearm ticks: got %0d want 9", ticks_a); end
      do_clear(0);
   endtask

   task automatic test_random();
      bit          inst;
      int          a, r;
      logic        o_done, o_to;
      logic [7:0]  o_code;
      logic [1:0]  o_ch;
      logic [3:0]  o_mask;
      logic [31:0] o_ticks, got_st, exp_st;
      for (int run = 0; run < 24; run++) begin
         inst = (run % 2) == 1;
         for (int c = 0; c < 4; c++) begin
            a = $urandom_range(0, 340);
            for (int t = 0; t < TL; t++) begin
               r = $urandom_range(0, 3);
               if (t < a) tr[t][c] = (r % 2 == 1) ? 8'hFF : 8'h00;
               else if (r < 2) tr[t][c] = 8'($urandom_range(1, 254));
               else tr[t][c] = (r == 2) ? 8'h00 : 8'hFF;
            end
         end
         model(inst);
         play(inst, m_end + 3);
         o_done  = inst ? done_b : done_a;
         o_to    = inst ? to_b : to_a;
         o_code  = inst ? code_b : code_a;
         o_ch    = inst ? ch_b : ch_a;
         o_mask  = inst ? mask_b : mask_a;
         o_ticks = inst ? ticks_b : ticks_a;
         n_tests++; if (obs_done !== m_end + 1) begin n_fail++; $display("FAIL rnd%0d done edge: got %0d want %0d", run, obs_done, m_end + 1); end
         n_tests++; if (o_done !== 1'b1) begin n_fail++; $display("FAIL rnd%0d done: got %b want 1", run, o_done); end
         n_tests++; if (o_to !== m_to) begin n_fail++; $display("FAIL rnd%0d timed_out: got %b want %b", run, o_to, m_to); end
         n_tests++; if (o_code !== m_code) begin n_fail++; $display("FAIL rnd%0d code: got %h want %h", run, o_code, m_code); end
         n_tests++; if (o_ch !== m_ch) begin n_fail++; $display("FAIL rnd%0d code_ch: got %0d want %0d", run, o_ch, m_ch); end
         n_tests++; if (o_mask !== m_mask) begin n_fail++; $display("FAIL rnd%0d fin_mask: got %b want %b", run, o_mask, m_mask); end
         n_tests++; if (o_ticks !== m_ticks) begin n_fail++; $display("FAIL rnd%0d ticks: got %0d want %0d", run, o_ticks, m_ticks); end
`ifdef KIWI_RUN_MONITOR_STAMP_EN
         for (int c = 0; c < 4; c++) begin
            exp_st = m_mask[c] ? 32'(m_first[c]) : 32'd0;
            got_st = inst ? stamp_b[c*32 +: 32] : stamp_a[c*32 +: 32];
            n_tests++; if (got_st !== exp_st) begin n_fail++; $display("FAIL rnd%0d stamp ch%0d: got %0d want %0d", run, c, got_st, exp_st); end
         end
`endif
         do_clear(inst);
      end
   endtask

   initial begin
      start_a = 1'b0;
      clear_a = 1'b0;
      start_b = 1'b0;
      clear_b = 1'b0;
      syn_a = '0;
      syn_b = '0;
      test_reset();
      test_basic_finish();
      test_glitch();
      test_all_mode();
      test_control();
      test_idle_marker();
      test_reset_mid_settle();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/kiwi_run_monitor.md
Name: kiwi_run_monitor

Overview:
- Synthesisable, multi-channel run monitor for Kiwi-generated DUTs. Watches N_CH abend-syndrome buses, counts clock ticks, debounces completion over a settle window, and enforces a timeout watchdog.
- Reports a single latched completion code and the channel that produced it.
- Sits between the DUT(s) and the host/test harness; replaces the testbench-only finish logic so the same checking runs on FPGA and in simulation.

Parameters:
- N_CH, 4, number of monitored syndrome channels (1..16).
- SYN_W, 8, syndrome width per channel.
- SETTLE, 8, cycles the finish condition is held before completion is declared (1..255).
- CNT_W, 32, tick counter width.
- TIMEOUT, 1000000, tick limit before forced stop; 0 disables the watchdog.
- ALL_MODE, 0, 0 = finish when any channel finishes; 1 = finish when every channel has finished.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; arms the monitor from IDLE.
- clear  in  1  one-cycle pulse; returns DONE/TOUT to IDLE.
- hpr_abend_syndrome  in  N_CH*SYN_W  packed syndromes; channel i at bits [i*SYN_W +: SYN_W].
- busy  out  1  high in RUN or SETTLE.
- done  out  1  high in DONE or TOUT.
- timed_out  out  1  high in TOUT only.
- code  out  SYN_W  latched completion code.
- code_ch  out  $clog2(N_CH) (min 1)  channel that supplied code.
- fin_mask  out  N_CH  channels seen finished (sticky while armed).
- clock_ticks  out  CNT_W  cycles since arming, saturating.

Behaviour:
- Channel finished: syndrome != 0 and syndrome != all-ones. 0 means running; all-ones means healthy idle.
- Reset (reset low, asynchronous): state IDLE; busy=0, done=0, timed_out=0, code=0, code_ch=0, fin_mask=0, clock_ticks=0.
- IDLE: start -> RUN, clearing clock_ticks, fin_mask, code and code_ch on the same edge. Syndromes are ignored in IDLE.
- RUN:
  - clock_ticks increments every cycle and saturates at all-ones.
  - fin_mask[i] is set on any cycle channel i is finished, and stays set.
  - Trigger: ALL_MODE=0 -> fin_mask != 0 (including the bit being set this cycle). ALL_MODE=1 -> fin_mask all ones.
  - Trigger -> SETTLE with a settle counter of 0.
- SETTLE:
  - clock_ticks keeps counting and fin_mask keeps accumulating.
  - The trigger is sticky: a syndrome returning to 0 does not abort SETTLE.
  - After exactly SETTLE cycles in SETTLE, go to DONE. On that edge, code and code_ch are latched from the lowest-index channel that is finished at that cycle.
  - If no channel is finished at that cycle, code and code_ch come from the lowest-index set bit of fin_mask, using that channel's current syndrome value.
- Timeout:
  - With TIMEOUT != 0, in RUN or SETTLE, reaching clock_ticks == TIMEOUT-1 moves the next edge to TOUT.
  - TOUT latches code = all-ones and code_ch = 0, and freezes clock_ticks.
  - If timeout and settle expiry occur on the same edge, DONE wins.
- DONE/TOUT: all outputs are held. clear -> IDLE, and only done, timed_out and the state are cleared. code, fin_mask and clock_ticks stay readable until the next start.
- Ignored pulses: start outside IDLE; clear outside DONE/TOUT.
- start and clear asserted together in IDLE: start wins.
- Latency: trigger cycle T gives done=1 visible after edge T+SETTLE+1.
- No combinational path from the inputs to any output; all outputs are registered.

Optional Feature:
- Macro: KIWI_RUN_MONITOR_STAMP_EN.
- Defined:
  - Adds output port fin_stamp, N_CH*CNT_W wide.
  - Per channel, it captures the clock_ticks value on the cycle fin_mask[i] first sets.
  - It is cleared on reset and on start, and holds after DONE/TOUT.
- Undefined: the port and its registers are absent; all other behaviour is identical.

Decomposition:
- Package kiwi_mon_pkg holds:
  - the state enum (IDLE, RUN, SETTLE, DONE, TOUT);
  - the SYN_OK=0 and SYN_IDLE=all-ones constants;
  - the function is_finished(syn).
- One sub-module, kiwi_mon_prio_sel: combinational lowest-index-set selector over N_CH. Given a request mask, it returns {valid, index}. Used for code/code_ch selection.

Test Plan:
- Basic finish: N_CH=4, ALL_MODE=0, SETTLE=8. start at cycle 0; ch2 syndrome goes 0x00 -> 0x01 at tick 20 -> done rises at tick 29, code=0x01, code_ch=2, fin_mask=0100, timed_out=0.
- Idle marker: all channels held at 0xFF for 500 cycles with TIMEOUT=300 -> no trigger; timed_out=1, code=0xFF, clock_ticks=299 frozen.
- Priority and glitch: ch3=0x05 at tick 10, ch1=0x07 at tick 12, ch3 back to 0 at tick 14 -> sticky SETTLE; done at tick 19, code=0x07, code_ch=1, fin_mask=1010.
- ALL_MODE=1: channels finish at ticks 5, 9, 40, 41 -> SETTLE begins at tick 41, done at tick 50, code from ch0.
- Reset mid-SETTLE: reset low for 1 cycle at tick 25 -> all outputs 0 immediately and asynchronously, state IDLE. A later start re-arms cleanly, with clock_ticks restarting at 0.
- Control pulses: start pulsed during RUN -> ignored; clear in DONE -> done=0 while code is retained. With STAMP_EN defined, fin_stamp for ch2=20 in the basic-finish case.
